// File: rtl/md5_cmd_pkg.sv
// Opcodes, response bytes, FSM state encoding and the tx request record for the MD5 host command path.
package md5_cmd_pkg;

  localparam logic [7:0] CMD_SET_HASH_OP   = 8'h01;
  localparam logic [7:0] CMD_SEND_TEXT_OP  = 8'h02;
  localparam logic [7:0] CMD_READ_MATCH_OP = 8'h03;
  localparam logic [7:0] CMD_TEST_OP       = 8'h04;

  localparam logic [7:0] ACK_OK      = 8'h01;
  localparam logic [7:0] ACK_NOMATCH = 8'h00;
  localparam logic [7:0] NAK         = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HASH,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_TEXT,
    ST_WAIT_PROC,
    ST_TX,
    ST_TX_WAIT
  } state_t;

  // cnt bytes of payload are sent, most significant of those bytes first
  typedef struct packed {
    logic [2:0]  cnt;
    logic [31:0] payload;
  } tx_req_t;

  function automatic tx_req_t tx_one(input logic [7:0] b);
    tx_req_t r;
    r.cnt     = 3'd1;
    r.payload = {24'h0, b};
    return r;
  endfunction

endpackage

// File: rtl/cmd_tx_sequencer.sv
// Sends 1-4 payload bytes MSB first: tx_start only while tx_busy is low, one byte in flight, done pulses once the last byte drains.
// Latency: first tx_start two cycles after load when idle; stalls indefinitely while the transmitter holds tx_busy.
module cmd_tx_sequencer import md5_cmd_pkg::*; (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  tx_req_t    req,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_ISSUE,
    SQ_START,
    SQ_SKIP,
    SQ_WAIT
  } sq_state_t;

  sq_state_t   state;
  logic [31:0] shreg;
  logic [2:0]  left;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SQ_IDLE;
      shreg    <= '0;
      left     <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        SQ_IDLE: begin
          if (load) begin
            left <= req.cnt;
            // left-align the bytes to send so each one leaves from the top
            case (req.cnt)
              3'd1:    shreg <= {req.payload[7:0], 24'h0};
              3'd2:    shreg <= {req.payload[15:0], 16'h0};
              3'd3:    shreg <= {req.payload[23:0], 8'h0};
              default: shreg <= req.payload;
            endcase
            state <= SQ_ISSUE;
          end
        end
        SQ_ISSUE: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= shreg[31:24];
            shreg    <= {shreg[23:0], 8'h0};
            left     <= left - 3'd1;
            state    <= SQ_START;
          end
        end
        // the transmitter needs a cycle after tx_start before tx_busy is trustworthy
        SQ_START: state <= SQ_SKIP;
        SQ_SKIP:  state <= SQ_WAIT;
        SQ_WAIT: begin
          if (!tx_busy) begin
            if (left == 3'd0) begin
              done  <= 1'b1;
              state <= SQ_IDLE;
            end else begin
              state <= SQ_ISSUE;
            end
          end
        end
        default: state <= SQ_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes host opcode frames: loads the target hash, streams text to the matcher, answers with ack/result/data bytes.
// Latency: text byte one cycle after rx_ready; rx bytes during WAIT_PROC/TX are dropped, tx waits on tx_busy.
module uart_cmd_responder import md5_cmd_pkg::*; #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int TIMEOUT_US    = 1000,
  parameter int TEST_LEN      = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_ready,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [127:0] target_hash,
  output logic         hash_valid,
  output logic         text_valid,
  output logic [7:0]   text_byte,
  output logic         text_last,
  input  logic         proc_done,
  input  logic         proc_match,
  input  logic [31:0]  match_pos,
  output logic         busy
);

  localparam logic [63:0] TIMEOUT_CYCLES = 64'(TIMEOUT_US) * 64'(CLK_FREQUENCY) / 64'd1_000_000;
  localparam bit          TIMEOUT_EN     = (TIMEOUT_CYCLES != 64'd0);
  localparam int          TO_W           = (TIMEOUT_CYCLES > 64'd1) ? $clog2(TIMEOUT_CYCLES + 64'd1) : 1;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 64'd1);

  state_t          state;
  tx_req_t         tx_req;
  logic [15:0]     byte_cnt;
  logic [15:0]     byte_nxt;
  logic [15:0]     text_len;
  logic [7:0]      test_left;
  logic [TO_W-1:0] to_cnt;
  logic            in_frame;
  logic            to_hit;
  logic            seq_load;
  logic            seq_done;

  assign busy     = (state != ST_IDLE);
  assign seq_load = (state == ST_TX);
  assign byte_nxt = byte_cnt + 16'd1;
  assign in_frame = (state == ST_HASH) || (state == ST_LEN_HI) ||
                    (state == ST_LEN_LO) || (state == ST_TEXT);
  assign to_hit   = TIMEOUT_EN && in_frame && !rx_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (!in_frame || rx_ready || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tx_req      <= '0;
      byte_cnt    <= '0;
      text_len    <= '0;
      test_left   <= '0;
      target_hash <= '0;
      hash_valid  <= 1'b0;
      text_valid  <= 1'b0;
      text_byte   <= '0;
      text_last   <= 1'b0;
    end else begin
      text_valid <= 1'b0;
      text_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_ready) begin
            byte_cnt  <= '0;
            test_left <= '0;
            case (rx_data)
              CMD_SET_HASH_OP:   state <= ST_HASH;
              CMD_SEND_TEXT_OP:  state <= ST_LEN_HI;
              CMD_READ_MATCH_OP: begin
                tx_req <= '{cnt: 3'd4, payload: match_pos};
                state  <= ST_TX;
              end
              CMD_TEST_OP: begin
                tx_req    <= tx_one(8'(TEST_LEN));
                test_left <= 8'(TEST_LEN - 1);
                state     <= ST_TX;
              end
              default: begin
                tx_req <= tx_one(NAK);
                state  <= ST_TX;
              end
            endcase
          end
        end
        ST_HASH: begin
          if (rx_ready) begin
            target_hash <= {target_hash[119:0], rx_data};
            byte_cnt    <= byte_nxt;
            if (byte_cnt == 16'd15) begin
              hash_valid <= 1'b1;
              tx_req     <= tx_one(ACK_OK);
              state      <= ST_TX;
            end
          end else if (to_hit) begin
            hash_valid <= 1'b0;
            tx_req     <= tx_one(NAK);
            state      <= ST_TX;
          end
        end
        ST_LEN_HI: begin
          if (rx_ready) begin
            text_len[15:8] <= rx_data;
            state          <= ST_LEN_LO;
          end else if (to_hit) begin
            tx_req <= tx_one(NAK);
            state  <= ST_TX;
          end
        end
        ST_LEN_LO: begin
          if (rx_ready) begin
            text_len[7:0] <= rx_data;
            if ({text_len[15:8], rx_data} == 16'd0) begin
              tx_req <= tx_one(ACK_NOMATCH);
              state  <= ST_TX;
            end else begin
              state <= ST_TEXT;
            end
          end else if (to_hit) begin
            tx_req <= tx_one(NAK);
            state  <= ST_TX;
          end
        end
        ST_TEXT: begin
          if (rx_ready) begin
            text_valid <= 1'b1;
            text_byte  <= rx_data;
            byte_cnt   <= byte_nxt;
            if (byte_nxt == text_len) begin
              text_last <= 1'b1;
              state     <= ST_WAIT_PROC;
            end
          end else if (to_hit) begin
            // close the matcher's block with a dummy last byte; its verdict is never read
            text_valid <= 1'b1;
            text_last  <= 1'b1;
            text_byte  <= '0;
            tx_req     <= tx_one(NAK);
            state      <= ST_TX;
          end
        end
        ST_WAIT_PROC: begin
          if (proc_done) begin
            tx_req <= tx_one({7'b0, proc_match});
            state  <= ST_TX;
          end
        end
        ST_TX: state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (seq_done) begin
            if (test_left != 8'd0) begin
              tx_req    <= tx_one(test_left);
              test_left <= test_left - 8'd1;
              state     <= ST_TX;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cmd_tx_sequencer u_tx_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (seq_load),
    .req      (tx_req),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (seq_done)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Command-level bench: random bytes and gaps, a modelled transmitter with random busy, expectations from the byte protocol.
module tb_uart_cmd_responder;

  localparam int CLK_HZ   = 100_000_000;
  localparam int TOUT_US  = 2;
  localparam int TOUT_CYC = TOUT_US * (CLK_HZ / 1_000_000);
  localparam int TLEN     = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_ready = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         tx_busy = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [127:0] target_hash;
  logic         hash_valid;
  logic         text_valid;
  logic [7:0]   text_byte;
  logic         text_last;
  logic         proc_done = 1'b0;
  logic         proc_match = 1'b0;
  logic [31:0]  match_pos = '0;
  logic         busy;

  int vec = 0;
  int errs = 0;
  int viol = 0;
  int busy_left = 0;
  logic [7:0]   tx_q[$];
  logic [7:0]   txt_q[$];
  logic         txt_last_q[$];
  logic         s_tv, s_tl;
  logic [7:0]   s_tb;
  logic [127:0] m_hash = '0;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .CLK_FREQUENCY (CLK_HZ),
    .TIMEOUT_US    (TOUT_US),
    .TEST_LEN      (TLEN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .target_hash (target_hash),
    .hash_valid  (hash_valid),
    .text_valid  (text_valid),
    .text_byte   (text_byte),
    .text_last   (text_last),
    .proc_done   (proc_done),
    .proc_match  (proc_match),
    .match_pos   (match_pos),
    .busy        (busy)
  );

  // transmitter model (busy after each tx_start, plus spontaneous busy) and output monitors
  always @(negedge clk) begin
    if (text_valid) begin
      txt_q.push_back(text_byte);
      txt_last_q.push_back(text_last);
    end
    if (tx_start) begin
      if (tx_busy) viol++;
      tx_q.push_back(tx_data);
      tx_busy   = 1'b1;
      busy_left = $urandom_range(2, 12);
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end else if ($urandom_range(0, 15) == 0) begin
      tx_busy   = 1'b1;
      busy_left = $urandom_range(1, 6);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [63:0] tx_packed();
    logic [63:0] r = '0;
    foreach (tx_q[i]) r = {r[55:0], tx_q[i]};
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    s_tv = text_valid;
    s_tb = text_byte;
    s_tl = text_last;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clear_q();
    tx_q.delete();
    txt_q.delete();
    txt_last_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({tx_start, tx_data, hash_valid, text_valid, text_byte, text_last, busy} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got tx_start=%b tx_data=%h hash_valid=%b text_valid=%b text_byte=%h text_last=%b busy=%b, want all 0",
               tx_start, tx_data, hash_valid, text_valid, text_byte, text_last, busy);
    end
    vec++;
    if (target_hash !== '0) begin
      errs++;
      $display("FAIL reset_hash: got %h want 0", target_hash);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: busy=%b tx_start=%b, want 0 0", busy, tx_start);
    end
  endtask

  task automatic test_set_hash(input logic [127:0] h);
    clear_q();
    send_byte(8'h01, $urandom_range(0, 10));
    for (int i = 0; i < 16; i++) send_byte(h[127-8*i -: 8], $urandom_range(0, 20));
    m_hash = h;
    wait_idle(2000);
    vec++;
    if (target_hash !== m_hash) begin
      errs++;
      $display("FAIL set_hash value: got %h want %h", target_hash, m_hash);
    end
    vec++;
    if (hash_valid !== 1'b1) begin
      errs++;
      $display("FAIL set_hash valid: got %b want 1", hash_valid);
    end
    vec++;
    if (tx_q.size() != 1 || tx_packed() !== 64'h01) begin
      errs++;
      $display("FAIL set_hash ack: got %0d bytes %h, want 1 byte 01", tx_q.size(), tx_packed());
    end
  endtask

  task automatic test_send_text(input int len, input logic pm);
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int bad = 0;
    clear_q();
    proc_match = ~pm;
    send_byte(8'h02, $urandom_range(0, 10));
    send_byte(8'(len >> 8), $urandom_range(0, 10));
    send_byte(8'(len), $urandom_range(0, 10));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, $urandom_range(0, 20));
      vec++;
      if (s_tv !== 1'b1 || s_tb !== b || s_tl !== (i == len - 1)) begin
        errs++;
        $display("FAIL text_latency byte %0d: valid=%b byte=%h last=%b, want valid=1 byte=%h last=%b",
                 i, s_tv, s_tb, s_tl, b, (i == len - 1));
      end
    end
    if (len > 0) begin
      send_byte(8'($urandom), $urandom_range(1, 10));
      @(negedge clk);
      proc_done  = 1'b1;
      proc_match = pm;
      @(negedge clk);
      proc_done  = 1'b0;
      proc_match = ~pm;
    end
    wait_idle(3000);
    vec++;
    if (txt_q.size() != len) begin
      errs++;
      $display("FAIL text_count: got %0d pulses want %0d", txt_q.size(), len);
    end
    for (int i = 0; i < len && i < txt_q.size(); i++)
      if (txt_q[i] !== exp_q[i] || txt_last_q[i] !== (i == len - 1)) bad++;
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL text_stream: %0d bytes wrong in data/last, want 0", bad);
    end
    vec++;
    if (tx_q.size() != 1 || tx_packed() !== {56'h0, 7'b0, pm}) begin
      errs++;
      $display("FAIL text_result: got %0d bytes %h, want 1 byte %h", tx_q.size(), tx_packed(), {7'b0, pm});
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL text_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_read_match(input logic [31:0] mp);
    clear_q();
    match_pos = mp;
    send_byte(8'h03, 0);
    match_pos = ~mp;
    wait_idle(2000);
    vec++;
    if (tx_q.size() != 4 || tx_packed() !== {32'h0, mp}) begin
      errs++;
      $display("FAIL read_match: got %0d bytes %h, want 4 bytes %h", tx_q.size(), tx_packed(), mp);
    end
    vec++;
    if (viol != 0) begin
      errs++;
      $display("FAIL tx_while_busy: got %0d starts during tx_busy, want 0", viol);
    end
  endtask

  task automatic test_test_cmd();
    logic [63:0] exp = '0;
    clear_q();
    for (int k = TLEN; k >= 1; k--) exp = {exp[55:0], 8'(k)};
    send_byte(8'h04, 0);
    wait_idle(2000);
    vec++;
    if (tx_q.size() != TLEN || tx_packed() !== exp) begin
      errs++;
      $display("FAIL test_cmd: got %0d bytes %h, want %0d bytes %h", tx_q.size(), tx_packed(), TLEN, exp);
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL test_cmd idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_nak(input logic [7:0] op);
    clear_q();
    send_byte(op, 0);
    wait_idle(2000);
    vec++;
    if (tx_q.size() != 1 || tx_packed() !== 64'hEE || busy !== 1'b0) begin
      errs++;
      $display("FAIL nak op %h: got %0d bytes %h busy=%b, want 1 byte ee busy=0", op, tx_q.size(), tx_packed(), busy);
    end
  endtask

  task automatic test_hash_timeout();
    logic [39:0] part = '0;
    logic [7:0]  b;
    clear_q();
    send_byte(8'h01, $urandom_range(0, 10));
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      part = {part[31:0], b};
      send_byte(b, $urandom_range(0, 20));
    end
    repeat (TOUT_CYC + 40) @(negedge clk);
    wait_idle(2000);
    m_hash = (m_hash << 40) | {88'h0, part};
    vec++;
    if (tx_q.size() != 1 || tx_packed() !== 64'hEE) begin
      errs++;
      $display("FAIL hash_timeout nak: got %0d bytes %h, want 1 byte ee", tx_q.size(), tx_packed());
    end
    vec++;
    if (hash_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL hash_timeout state: hash_valid=%b busy=%b, want 0 0", hash_valid, busy);
    end
    vec++;
    if (target_hash !== m_hash) begin
      errs++;
      $display("FAIL hash_timeout partial: got %h want %h", target_hash, m_hash);
    end
  endtask

  task automatic test_text_timeout();
    clear_q();
    send_byte(8'h02, 2);
    send_byte(8'h00, 2);
    send_byte(8'h0A, 2);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(1, 255)), $urandom_range(0, 20));
    repeat (TOUT_CYC + 40) @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    wait_idle(2000);
    vec++;
    if (txt_q.size() != 4 || txt_q[3] !== 8'h00 || txt_last_q[3] !== 1'b1) begin
      errs++;
      $display("FAIL text_timeout close: got %0d pulses, want 4 with final byte 00 last=1", txt_q.size());
    end
    vec++;
    if (tx_q.size() != 1 || tx_packed() !== 64'hEE || busy !== 1'b0) begin
      errs++;
      $display("FAIL text_timeout nak: got %0d bytes %h busy=%b, want 1 byte ee busy=0", tx_q.size(), tx_packed(), busy);
    end
  endtask

  task automatic test_reset_mid_text();
    logic [7:0] b;
    clear_q();
    send_byte(8'h02, 2);
    send_byte(8'h00, 2);
    send_byte(8'h64, 2);
    for (int i = 0; i < 37; i++) begin
      b = (i == 36) ? 8'($urandom_range(1, 255)) : 8'($urandom);
      send_byte(b, (i == 36) ? 0 : $urandom_range(0, 10));
    end
    vec++;
    if (s_tv !== 1'b1 || s_tb !== b) begin
      errs++;
      $display("FAIL mid_text byte37: valid=%b byte=%h, want 1 %h", s_tv, s_tb, b);
    end
    reset_n = 1'b0;
    #1;
    vec++;
    if ({tx_start, tx_data, hash_valid, text_valid, text_byte, text_last, busy} !== '0) begin
      errs++;
      $display("FAIL mid_text reset: tx_start=%b tx_data=%h hash_valid=%b text_valid=%b text_byte=%h text_last=%b busy=%b, want all 0",
               tx_start, tx_data, hash_valid, text_valid, text_byte, text_last, busy);
    end
    vec++;
    if (target_hash !== '0) begin
      errs++;
      $display("FAIL mid_text reset hash: got %h want 0", target_hash);
    end
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    m_hash  = '0;
    repeat (2) @(negedge clk);
    vec++;
    if (hash_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_text release: hash_valid=%b busy=%b, want 0 0", hash_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_set_hash(128'h1d5468d37f38dc34dca0692c3a6f2c83);
    test_send_text(100, 1'b0);
    test_send_text(100, 1'b1);
    test_send_text($urandom_range(1, 40), 1'($urandom));
    test_read_match(32'h0000_0320);
    test_read_match($urandom);
    test_test_cmd();
    test_nak(8'h7F);
    test_nak(8'h00);
    test_nak(8'($urandom_range(5, 255)));
    test_hash_timeout();
    test_set_hash({$urandom, $urandom, $urandom, $urandom});
    test_text_timeout();
    test_reset_mid_text();
    test_send_text(0, 1'b0);
    vec++;
    if (viol != 0) begin
      errs++;
      $display("FAIL tx_while_busy total: got %0d, want 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
